// File: rtl/sd_block_responder.sv
// Responder side of the virtual-disk sector protocol. It serves 512-byte
// sector reads and writes for VDNUM drives from a byte-wide backing memory.
// All outputs are registered. Each output flop is loaded on the transition
// into the state where it must be visible, so the pulses line up with the
// states named below.
module sd_block_responder #(
    parameter int unsigned VDNUM = 3,
    parameter int unsigned DRV_W = 2,
    parameter int unsigned LBA_W = 14,
    parameter int unsigned AW    = DRV_W + LBA_W + 9
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [31:0]      sd_lba,
    input  logic [VDNUM-1:0] sd_rd,
    input  logic [VDNUM-1:0] sd_wr,
    output logic             sd_ack,
    output logic [8:0]       sd_buff_addr,
    output logic [7:0]       sd_buff_dout,
    output logic             sd_buff_wr,
    input  logic [7:0]       sd_buff_din,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [7:0]       mem_din,
    input  logic [7:0]       mem_dout,
    input  logic             mem_ready,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(511);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ACK      = 4'd1,
        RD_REQ   = 4'd2,
        RD_WAIT  = 4'd3,
        RD_PUT   = 4'd4,
        WR_ADDR  = 4'd5,
        WR_LATCH = 4'd6,
        WR_REQ   = 4'd7,
        WR_WAIT  = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [DRV_W-1:0]   drv_q, drv_d;
    logic               wr_q, wr_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               oor_q, oor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sd_ack_q, sd_ack_d;
    logic [8:0]         sd_buff_addr_q, sd_buff_addr_d;
    logic [7:0]         sd_buff_dout_q, sd_buff_dout_d;
    logic               sd_buff_wr_q, sd_buff_wr_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [7:0]         mem_din_q, mem_din_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               req_any_c;
    logic [DRV_W-1:0]   sel_drv_c;
    logic               sel_wr_c;
    logic               sel_oor_c;
    logic               wr_step_c;

    // Pick the lowest-index requesting drive. A read wins over a write on the same drive.
    always_comb begin
        req_any_c = |(sd_rd | sd_wr);
        sel_drv_c = '0;
        sel_wr_c  = 1'b0;
        for (int i = int'(VDNUM) - 1; i >= 0; i--) begin
            if (sd_rd[i] || sd_wr[i]) begin
                sel_drv_c = DRV_W'(i);
                sel_wr_c  = ~sd_rd[i];
            end
        end
        sel_oor_c = |sd_lba[31:LBA_W];
    end

    // Next-state and registered-output computation for the sector transfer.
    always_comb begin
        state_d        = state_q;
        drv_d          = drv_q;
        wr_d           = wr_q;
        lba_d          = lba_q;
        oor_d          = oor_q;
        cnt_d          = cnt_q;
        sd_ack_d       = sd_ack_q;
        sd_buff_addr_d = sd_buff_addr_q;
        sd_buff_dout_d = sd_buff_dout_q;
        sd_buff_wr_d   = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_rd_d       = 1'b0;
        mem_wr_d       = 1'b0;
        mem_din_d      = mem_din_q;
        err_d          = 1'b0;
        wr_step_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any_c) begin
                    state_d  = ACK;
                    drv_d    = sel_drv_c;
                    wr_d     = sel_wr_c;
                    lba_d    = sd_lba[LBA_W-1:0];
                    oor_d    = sel_oor_c;
                    cnt_d    = '0;
                    sd_ack_d = 1'b1;
                    err_d    = sel_oor_c;
                end
            end
            ACK: begin
                if (wr_q) begin
                    state_d        = WR_ADDR;
                    sd_buff_addr_d = cnt_q;
                end else begin
                    state_d    = RD_REQ;
                    mem_addr_d = AW'({drv_q, lba_q, cnt_q});
                    mem_rd_d   = ~oor_q;
                end
            end
            RD_REQ: begin
                // An out-of-range sector reads as all 0xFF and skips memory.
                if (oor_q) begin
                    state_d        = RD_PUT;
                    sd_buff_dout_d = 8'hFF;
                    sd_buff_addr_d = cnt_q;
                    sd_buff_wr_d   = 1'b1;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    state_d        = RD_PUT;
                    sd_buff_dout_d = mem_dout;
                    sd_buff_addr_d = cnt_q;
                    sd_buff_wr_d   = 1'b1;
                end
            end
            RD_PUT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    sd_ack_d = 1'b0;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    state_d    = RD_REQ;
                    mem_addr_d = AW'({drv_q, lba_q, cnt_d});
                    mem_rd_d   = ~oor_q;
                end
            end
            WR_ADDR: begin
                state_d = WR_LATCH;
            end
            WR_LATCH: begin
                // The buffer address has been stable for one cycle, so its data is valid now.
                state_d    = WR_REQ;
                mem_din_d  = sd_buff_din;
                mem_addr_d = AW'({drv_q, lba_q, cnt_q});
                mem_wr_d   = ~oor_q;
            end
            WR_REQ: begin
                if (oor_q) begin
                    wr_step_c = 1'b1;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                wr_step_c = mem_ready;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Advance to the next write byte, or finish the sector.
        if (wr_step_c) begin
            if (cnt_q == CNT_LAST) begin
                state_d  = DONE;
                sd_ack_d = 1'b0;
            end else begin
                cnt_d          = cnt_q + CNT_W'(1);
                state_d        = WR_ADDR;
                sd_buff_addr_d = cnt_d;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            drv_q          <= '0;
            wr_q           <= 1'b0;
            lba_q          <= '0;
            oor_q          <= 1'b0;
            cnt_q          <= '0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= '0;
            sd_buff_dout_q <= '0;
            sd_buff_wr_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_din_q      <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            drv_q          <= drv_d;
            wr_q           <= wr_d;
            lba_q          <= lba_d;
            oor_q          <= oor_d;
            cnt_q          <= cnt_d;
            sd_ack_q       <= sd_ack_d;
            sd_buff_addr_q <= sd_buff_addr_d;
            sd_buff_dout_q <= sd_buff_dout_d;
            sd_buff_wr_q   <= sd_buff_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_din_q      <= mem_din_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign sd_ack       = sd_ack_q;
    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign sd_buff_wr   = sd_buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_din      = mem_din_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Scoreboard bench for sd_block_responder: the stimulus pushes expected
// buffer writes and memory accesses, and a negedge monitor pops them and
// compares them as the DUT produces them.
module tb_sd_block_responder;

    localparam int unsigned AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   sd_lba;
    logic [2:0]    sd_rd;
    logic [2:0]    sd_wr;
    logic          sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_din;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          mem_ready;
    logic          busy;
    logic          err;

    sd_block_responder dut (
        .clk_sys(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int err_cnt = 0;

    logic [16:0]   q_buf[$];   // {addr, data} expected on sd_buff_wr
    logic [AW-1:0] q_mr[$];    // expected mem_rd addresses
    logic [AW+7:0] q_mw[$];    // expected {mem_addr, mem_din} on mem_wr

    logic [7:0] bufm [0:511];
    bit lat_rand = 1'b0;
    bit spur_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    endtask

    // Sector buffer: 1-cycle read latency.
    always @(posedge clk) sd_buff_din <= bufm[sd_buff_addr];

    // Backing memory: returns addr[7:0]^0x5A, latency 1 or random 1..7, one access at a time.
    bit            m_pend = 1'b0;
    int            m_cd = 0;
    int            m_lat = 1;
    logic [AW-1:0] m_addr = '0;
    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
            m_lat  = lat_rand ? int'($urandom_range(7, 1)) : 1;
            m_addr = mem_addr;
            if (m_lat == 1) begin
                mem_ready <= 1'b1;
                mem_dout  <= m_addr[7:0] ^ 8'h5A;
            end else begin
                m_pend = 1'b1;
                m_cd   = m_lat - 1;
            end
        end else if (m_pend) begin
            m_cd--;
            if (m_cd == 0) begin
                m_pend    = 1'b0;
                mem_ready <= 1'b1;
                mem_dout  <= m_addr[7:0] ^ 8'h5A;
            end
        end else if (spur_en && busy === 1'b0 && $urandom_range(2, 0) == 0) begin
            mem_ready <= 1'b1;
            mem_dout  <= 8'hEE;
        end
    end

    // Monitor: pop and compare each output event.
    always @(negedge clk) begin
        logic [16:0]   eb;
        logic [AW-1:0] er;
        logic [AW+7:0] ew;
        if (err === 1'b1) err_cnt++;
        if (mem_rd === 1'b1 || mem_wr === 1'b1) chk("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'd0);
        if (sd_buff_wr === 1'b1) begin
            if (q_buf.size() == 0) begin
                n_chk++;
                $display("FAIL buf_wr_extra got addr=%0d data=%02h want none", sd_buff_addr, sd_buff_dout);
            end else begin
                eb = q_buf.pop_front();
                chk("buf_wr", 64'({sd_buff_addr, sd_buff_dout}), 64'(eb));
            end
        end
        if (mem_rd === 1'b1) begin
            if (q_mr.size() == 0) begin
                n_chk++;
                $display("FAIL mem_rd_extra got addr=%0h want none", mem_addr);
            end else begin
                er = q_mr.pop_front();
                chk("mem_rd_addr", 64'(mem_addr), 64'(er));
            end
        end
        if (mem_wr === 1'b1) begin
            if (q_mw.size() == 0) begin
                n_chk++;
                $display("FAIL mem_wr_extra got addr=%0h data=%02h want none", mem_addr, mem_din);
            end else begin
                ew = q_mw.pop_front();
                chk("mem_wr_addr_data", 64'({mem_addr, mem_din}), 64'(ew));
            end
        end
    end

    task automatic push_sector(input int d, input bit w, input logic [31:0] lba);
        logic          oor;
        logic [8:0]    i9;
        logic [AW-1:0] a;
        oor = |lba[31:14];
        for (int i = 0; i < 512; i++) begin
            i9 = 9'(i);
            a  = {2'(d), lba[13:0], i9};
            if (w) begin
                if (!oor) q_mw.push_back({a, i9[7:0] ^ 8'hC3});
            end else begin
                if (!oor) q_mr.push_back(a);
                q_buf.push_back({i9, oor ? 8'hFF : (i9[7:0] ^ 8'h5A)});
            end
        end
    endtask

    task automatic wait_ack(input logic val, input int budget, input string name);
        int t = 0;
        while (sd_ack !== val && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(sd_ack), 64'(val));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_before_req", 64'(busy), 64'd0);
    endtask

    task automatic check_drained(input string tag);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_buf_left"}, 64'(q_buf.size()), 64'd0);
        chk({tag, "_rd_left"},  64'(q_mr.size()),  64'd0);
        chk({tag, "_wr_left"},  64'(q_mw.size()),  64'd0);
    endtask

    // One complete sector with the request dropped as soon as sd_ack is seen.
    task automatic run_sector(input int d, input bit w, input logic [31:0] lba, input string tag);
        logic oor;
        oor = |lba[31:14];
        wait_idle();
        push_sector(d, w, lba);
        err_cnt = 0;
        sd_lba  = lba;
        if (w) sd_wr[d] = 1'b1;
        else   sd_rd[d] = 1'b1;
        @(negedge clk);
        chk({tag, "_ack_rise"}, 64'(sd_ack), 64'd1);
        chk({tag, "_err"}, 64'(err), 64'(oor));
        sd_rd = '0;
        sd_wr = '0;
        wait_ack(1'b0, 20000, {tag, "_ack_fall"});
        check_drained(tag);
        chk({tag, "_err_count"}, 64'(err_cnt), 64'(oor));
    endtask

    initial begin
        int gap;
        int t;
        for (int i = 0; i < 512; i++) bufm[i] = 8'(i) ^ 8'hC3;
        reset = 1'b1; sd_lba = '0; sd_rd = '0; sd_wr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                                  mem_rd, mem_wr, mem_din, busy, err}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_sector(0, 1'b0, 32'd5, "read_d0");
        run_sector(2, 1'b1, 32'h3FFF, "write_d2");

        // Priority: drive1 read, drive1 write, drive2 read.
        wait_idle();
        push_sector(1, 1'b0, 32'h0042);
        push_sector(1, 1'b1, 32'h0042);
        push_sector(2, 1'b0, 32'h0042);
        sd_lba = 32'h0042;
        sd_rd  = 3'b110;
        sd_wr  = 3'b010;
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            t   = 0;
            while (sd_ack !== 1'b1 && t < 100) begin
                @(negedge clk);
                gap++;
                t++;
            end
            chk("prio_ack_rise", 64'(sd_ack), 64'd1);
            if (k > 0) chk("prio_ack_gap", 64'(gap >= 1), 64'd1);
            if (k == 0) sd_rd[1] = 1'b0;
            else if (k == 1) sd_wr[1] = 1'b0;
            else sd_rd[2] = 1'b0;
            wait_ack(1'b0, 20000, "prio_ack_fall");
        end
        check_drained("prio");

        run_sector(0, 1'b0, 32'h4000, "oor_read");
        run_sector(0, 1'b1, 32'h4000, "oor_write");

        // Reset mid-sector with sd_rd held; the sector is re-served in full.
        wait_idle();
        push_sector(0, 1'b0, 32'd7);
        sd_lba   = 32'd7;
        sd_rd[0] = 1'b1;
        t = 0;
        while (!(sd_buff_wr === 1'b1 && sd_buff_addr == 9'd100) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("reset_reached_byte100", 64'(sd_buff_addr), 64'd100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_outputs", 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                                     mem_rd, mem_wr, mem_din, busy, err}), 64'd0);
        q_buf.delete();
        q_mr.delete();
        q_mw.delete();
        push_sector(0, 1'b0, 32'd7);
        @(negedge clk);
        chk("reserve_ack_rise", 64'(sd_ack), 64'd1);
        sd_rd = '0;
        wait_ack(1'b0, 20000, "reserve_ack_fall");
        check_drained("reserve");

        // Random memory latency, with spurious ready pulses while idle.
        lat_rand = 1'b1;
        spur_en  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_spurious", 64'({busy, sd_ack, sd_buff_wr, mem_rd, mem_wr}), 64'd0);
        end
        run_sector(1, 1'b0, 32'h0123, "rand_read");
        run_sector(0, 1'b1, 32'h00AA, "rand_write");
        spur_en  = 1'b0;
        lat_rand = 1'b0;

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Responder end of the virtual-disk sector protocol (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*).
- Serves 512-byte sector reads and writes for up to VDNUM drives from a byte-wide backing memory port (SDRAM/BRAM arbiter) instead of the HPS.
- Drops in where hps_io normally drives the sd_* signals, so the initiator-side logic and its 512-byte sector buffer stay unchanged.
- Used for ROM/SDRAM-resident disk images and as the bench model for the initiator.

Parameters:
- VDNUM, 3, number of drives; request vectors are VDNUM bits wide.
- DRV_W, 2, drive index width; DRV_W >= clog2(VDNUM).
- LBA_W, 14, sector-index bits per drive (2^LBA_W sectors per drive).
- AW, DRV_W+LBA_W+9, backing memory byte-address width.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active high.
- sd_lba  in  32  sector number; sampled when a request is accepted.
- sd_rd  in  VDNUM  per-drive read request (level); initiator holds it until sd_ack is seen.
- sd_wr  in  VDNUM  per-drive write request (level), same rule.
- sd_ack  out  1  transfer in progress.
- sd_buff_addr  out  9  byte index within the sector buffer.
- sd_buff_dout  out  8  read data written into the sector buffer.
- sd_buff_wr  out  1  one-cycle sector-buffer write strobe.
- sd_buff_din  in  8  sector-buffer data; valid 1 cycle after sd_buff_addr changes.
- mem_addr  out  AW  backing address = {drive, lba[LBA_W-1:0], byte[8:0]}.
- mem_rd  out  1  one-cycle read pulse.
- mem_wr  out  1  one-cycle write pulse.
- mem_din  out  8  write data to memory.
- mem_dout  in  8  read data; valid when mem_ready is high.
- mem_ready  in  1  one-cycle completion pulse; earliest 1 cycle after mem_rd/mem_wr.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse when an out-of-range LBA is accepted.

Behaviour:
- Reset (synchronous, active high, 1 cycle):
  - State goes to IDLE.
  - All outputs go to 0: sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_din, busy, err.
  - Aborts any transfer mid-sector; a pending mem_ready arriving after reset is ignored.
  - Requests still high after reset are served from byte 0.
- States: IDLE, ACK, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_LATCH, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - If any bit of sd_rd|sd_wr is set, select the lowest-index drive with a request; read beats write on the same drive.
  - Latch drive, direction and sd_lba.
  - Set oor = |sd_lba[31:LBA_W]. If oor, pulse err in the next cycle.
  - Byte counter = 0. Go to ACK.
- ACK: assert sd_ack (1 cycle after acceptance). sd_ack stays high until DONE. Go to RD_REQ or WR_ADDR.
- RD_REQ:
  - mem_addr = {drv, lba, cnt}, mem_rd = 1 for this cycle only, then RD_WAIT.
  - If oor: no mem_rd; the data byte is 8'hFF; go straight to RD_PUT.
- RD_WAIT: on mem_ready, capture mem_dout into sd_buff_dout and go to RD_PUT. mem_ready arriving in any other state is ignored.
- RD_PUT:
  - sd_buff_addr = cnt and sd_buff_wr = 1 for one cycle; addr and data are stable throughout that cycle.
  - If cnt == 511, go to DONE; else cnt++ and go to RD_REQ.
- WR_ADDR: drive sd_buff_addr = cnt. Go to WR_LATCH.
- WR_LATCH: capture sd_buff_din into mem_din (the buffer's 1-cycle latency is now satisfied). Go to WR_REQ.
- WR_REQ:
  - mem_addr = {drv, lba, cnt}, mem_wr = 1 for one cycle, then WR_WAIT.
  - If oor: no mem_wr; the byte is discarded; advance as below.
- WR_WAIT: on mem_ready, if cnt == 511 go to DONE; else cnt++ and go to WR_ADDR.
- DONE:
  - Deassert sd_ack; sd_buff_addr holds its last value. Return to IDLE.
  - The next request may be accepted no earlier than the following cycle, so sd_ack is low for at least 1 cycle between sectors.
- Counter rules: cnt is 9 bits; a full sector is exactly 512 strobes. No wrap past 511 and no extra sd_buff_wr or mem_* pulses.
- Request vectors are ignored while busy. The initiator clears its request when it sees sd_ack; a request reasserted after DONE is a new sector.
- mem_rd and mem_wr are never high in the same cycle. At most one memory access is outstanding.

Test Plan:
- Read path: sd_rd=3'b001, sd_lba=5; memory returns addr[7:0]^8'h5A with ready 1 cycle after the pulse.
  - sd_ack rises 1 cycle after acceptance.
  - 512 sd_buff_wr pulses, addr 0..511, data matching the pattern.
  - mem_addr = {2'd0, 14'd5, i}; sd_ack falls once after byte 511.
- Write path: sd_wr=3'b100, sd_lba=14'h3FFF; sector buffer modelled as 1-cycle-latency RAM preloaded with i^8'hC3.
  - 512 mem_wr pulses with mem_din = i^8'hC3 and mem_addr = {2'd2, 14'h3FFF, i}.
- Priority: sd_rd=3'b110 and sd_wr=3'b010 set together; each request dropped on sd_ack.
  - Order served: drive1 read, then drive1 write, then drive2 read.
  - sd_ack low for at least 1 cycle between each.
- Out of range: sd_rd=3'b001, sd_lba=32'h4000.
  - err pulses once; 512 sd_buff_wr pulses with data 8'hFF; zero mem_rd pulses.
  - Same LBA with sd_wr: zero mem_wr pulses, and the handshake still completes.
- Reset at byte 100 of a read: next cycle all outputs are 0 and state is IDLE.
  - The still-held sd_rd is re-served from byte 0 to 511 completely.
- mem_ready delayed randomly 1-7 cycles, plus spurious mem_ready pulses in IDLE:
  - Data integrity holds; exactly 512 accesses per sector.
  - Spurious ready pulses cause no state change.
